// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, start/done handshake.
// Build option: define BCD_SATURATE_EN to clamp out-of-range results to 16'h9999.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int WORK_W = 4 * DIGITS;
    localparam int CNT_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_next;
    logic [IN_WIDTH-1:0] shift_reg, shift_next;
    logic [WORK_W-1:0]   work, work_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                ovf_pend, ovf_pend_next;
    logic [WORK_W-1:0]   bcd_next;
    logic                overflow_next;
    logic                done_next;

    logic [WORK_W-1:0]   adj;
    logic [WORK_W-1:0]   shifted_work;
    logic                bin_over;

    // Values above 9999 cannot be shown on four digits; the narrowest legal
    // widths can never reach this, so compare at full integer width.
    assign bin_over = 32'(bin) > 32'd9999;

    always_comb begin
        adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
            end
        end
    end

    // The carry out of the top digit would be a fifth decimal digit; it is dropped.
    assign shifted_work = WORK_W'({adj, shift_reg[IN_WIDTH-1]});

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        work_next     = work;
        cnt_next      = cnt;
        ovf_pend_next = ovf_pend;
        bcd_next      = bcd;
        overflow_next = overflow;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    shift_next    = bin;
                    work_next     = '0;
                    cnt_next      = '0;
                    ovf_pend_next = bin_over;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                work_next  = shifted_work;
                shift_next = {shift_reg[IN_WIDTH-2:0], 1'b0};
                cnt_next   = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    state_next    = IDLE;
                    done_next     = 1'b1;
                    overflow_next = ovf_pend;
`ifdef BCD_SATURATE_EN
                    bcd_next = ovf_pend ? {DIGITS{4'h9}} : shifted_work;
`else
                    bcd_next = shifted_work;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            work      <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            work      <= work_next;
            cnt       <= cnt_next;
            ovf_pend  <= ovf_pend_next;
            bcd       <= bcd_next;
            overflow  <= overflow_next;
            done      <= done_next;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: decimal-arithmetic reference model compared every
// cycle, plus directed conversions with hand-computed results (honours BCD_SATURATE_EN).
module tb_bin_to_bcd_seq;

    localparam int IN_WIDTH = 14;

    logic                CLK;
    logic                RST;
    logic                start;
    logic [IN_WIDTH-1:0] bin;
    logic                busy;
    logic                done;
    logic [15:0]         bcd;
    logic                overflow;

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion by decimal arithmetic.
    function automatic logic [15:0] to_bcd(input int value);
        int v;
        v = value;
        if (v > 9999) begin
`ifdef BCD_SATURATE_EN
            v = 9999;
`else
            v = v % 10000;
`endif
        end
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Behavioural model: a countdown of remaining clocks per accepted request.
    int          m_remain = 0;
    int          m_cap    = 0;
    logic        m_done   = 1'b0;
    logic [15:0] m_bcd    = 16'h0;
    logic        m_ovf    = 1'b0;
    logic        m_valid  = 1'b0;
    logic        m_rst    = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_remain <= 0;
            m_done   <= 1'b0;
            m_bcd    <= 16'h0;
            m_ovf    <= 1'b0;
            m_valid  <= 1'b1;
            m_rst    <= 1'b1;
        end else begin
            m_rst  <= 1'b0;
            m_done <= 1'b0;
            if (m_remain == 0) begin
                if (start) begin
                    m_cap    <= int'(bin);
                    m_remain <= IN_WIDTH;
                end
            end else begin
                m_remain <= m_remain - 1;
                if (m_remain == 1) begin
                    m_done <= 1'b1;
                    m_bcd  <= to_bcd(m_cap);
                    m_ovf  <= (m_cap > 9999);
                end
            end
        end
    end

    logic [15:0] prev_bcd;
    logic        prev_done;
    logic        prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (m_valid) begin
            check("busy", busy, m_remain != 0);
            check("done", done, m_done);
            check("bcd", bcd, m_bcd);
            check("overflow", overflow, m_ovf);
            check("bcd_digits", (bcd[15:12] > 9) || (bcd[11:8] > 9) || (bcd[7:4] > 9) || (bcd[3:0] > 9), 0);
            if (prev_valid) begin
                check("done_single", done && prev_done, 0);
                if (!done && !m_rst) check("bcd_hold", bcd, prev_bcd);
            end
            prev_bcd   <= bcd;
            prev_done  <= done;
            prev_valid <= 1'b1;
        end
    end

    task automatic convert(input int value, input logic [15:0] exp_bcd, input logic exp_ovf, input string tag);
        int edges;
        int busy_cnt;
        bit seen;
        @(negedge CLK);
        bin   = value[IN_WIDTH-1:0];
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start    = 1'b0;
        busy_cnt = int'(busy);
        seen     = 1'b0;
        edges    = 0;
        while (!seen && edges < 40) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (done) seen = 1'b1;
            else busy_cnt += int'(busy);
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, edges, IN_WIDTH);
        check({tag, "_busy_cycles"}, busy_cnt, IN_WIDTH);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_overflow"}, overflow, exp_ovf);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int cyc;
        int first_done;
        int second_done;

        RST   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_overflow", overflow, 0);
        RST = 1'b0;

        convert(0,    16'h0000, 1'b0, "zero");
        convert(1234, 16'h1234, 1'b0, "v1234");
        convert(9999, 16'h9999, 1'b0, "v9999");
        convert(10,   16'h0010, 1'b0, "v10");
`ifdef BCD_SATURATE_EN
        convert(16383, 16'h9999, 1'b1, "v16383");
        convert(10000, 16'h9999, 1'b1, "v10000");
`else
        convert(16383, 16'h6383, 1'b1, "v16383");
        convert(10000, 16'h0000, 1'b1, "v10000");
`endif

        // start while busy is ignored and later bin changes do not leak in
        @(negedge CLK);
        bin   = 14'd42;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        bin   = 14'd7;
        start = 1'b1;
        @(negedge CLK);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_bcd", bcd, 16'h0042);

        // start held high: back-to-back conversions every IN_WIDTH+1 clocks
        @(negedge CLK);
        start       = 1'b1;
        cyc         = 0;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            cyc++;
            if (done) begin
                if (first_done < 0) first_done = cyc;
                else if (second_done < 0) second_done = cyc;
            end
        end
        check("b2b_seen", (first_done > 0) && (second_done > 0), 1);
        check("b2b_period", second_done - first_done, IN_WIDTH + 1);
        check("b2b_bcd", bcd, 16'h0007);
        start = 1'b0;
        repeat (20) @(negedge CLK);

        // reset in the middle of a conversion discards it
        bin   = 14'd555;
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd, 16'h0000);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_bcd_after", bcd, 16'h0000);
        convert(555, 16'h0555, 1'b0, "v555");

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
